// File: rtl/i2c_pkg.sv
// Shared I2C constants and types used by both the target receiver and the bus master.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;
  localparam int unsigned I2C_CNT_W  = 4;

  // Bit index of the ninth clock, where the receiver drives ACK/NACK
  localparam logic [I2C_CNT_W-1:0] I2C_ACK_BIT = I2C_CNT_W'(8);

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  // Master-side timing defaults (system clocks per SCL phase)
  localparam int unsigned I2C_MST_CLK_DIV_STD  = 250;
  localparam int unsigned I2C_MST_CLK_DIV_FAST = 63;
  localparam int unsigned I2C_MST_SETUP_CYC    = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_STRETCH  = 3'd5,
    ST_IGNORE   = 3'd6
  } i2c_rx_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA and flags SCL edges plus START/STOP bus conditions.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda_s,
  output logic o_scl_rise_c,
  output logic o_scl_fall_c,
  output logic o_start_c,
  output logic o_stop_c
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl_s;
  logic                   w_sda_s;

  // Reset to 1 so a freshly released block sees an idle bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= SYNC_STAGES'({r_scl_sync, i_scl});
      r_sda_sync <= SYNC_STAGES'({r_sda_sync, i_sda});
      r_scl_d    <= w_scl_s;
      r_sda_d    <= w_sda_s;
    end
  end

  assign w_scl_s      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s      = r_sda_sync[SYNC_STAGES-1];
  assign o_sda_s      = w_sda_s;
  assign o_scl_rise_c = w_scl_s & ~r_scl_d;
  assign o_scl_fall_c = ~w_scl_s & r_scl_d;
  assign o_start_c    = w_scl_s & r_sda_d & ~w_sda_s;
  assign o_stop_c     = w_scl_s & ~r_sda_d & w_sda_s;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: ACKs its address, receives bytes into a one-deep
// holding slot and stretches SCL while that slot is still occupied.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_oe,
  output logic                  sda_oe,
  output logic [I2C_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy
);

  i2c_rx_state_e         r_state, w_state_n;
  logic [I2C_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_n;
  logic [I2C_DATA_W-1:0] r_shift, w_shift_n;
  logic [I2C_DATA_W-1:0] r_rx_data, w_rx_data_n;
  logic                  r_rx_valid, w_rx_valid_n;
  logic                  r_sda_oe, w_sda_oe_n;
  logic                  r_scl_oe, w_scl_oe_n;
  logic                  r_busy, w_busy_n;
  logic                  r_stretch_ld, w_stretch_ld_n;

  logic w_sda_s;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_slot_free;
  logic w_addr_hit;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_scl        (scl_i),
    .i_sda        (sda_i),
    .o_sda_s      (w_sda_s),
    .o_scl_rise_c (w_scl_rise),
    .o_scl_fall_c (w_scl_fall),
    .o_start_c    (w_start),
    .o_stop_c     (w_stop)
  );

  assign w_slot_free = ~r_rx_valid | rx_ready;
  assign w_addr_hit  = (r_shift[I2C_DATA_W-1:1] == TARGET_ADDR) && (r_shift[0] == I2C_RW_WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_sda_oe     <= 1'b0;
      r_scl_oe     <= 1'b0;
      r_busy       <= 1'b0;
      r_stretch_ld <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_bit_cnt    <= w_bit_cnt_n;
      r_shift      <= w_shift_n;
      r_rx_data    <= w_rx_data_n;
      r_rx_valid   <= w_rx_valid_n;
      r_sda_oe     <= w_sda_oe_n;
      r_scl_oe     <= w_scl_oe_n;
      r_busy       <= w_busy_n;
      r_stretch_ld <= w_stretch_ld_n;
    end
  end

  // Next-state and datapath; bus conditions override every state
  always_comb begin
    w_state_n      = r_state;
    w_bit_cnt_n    = r_bit_cnt;
    w_shift_n      = r_shift;
    w_rx_data_n    = r_rx_data;
    w_rx_valid_n   = r_rx_valid & ~rx_ready;
    w_sda_oe_n     = r_sda_oe;
    w_scl_oe_n     = r_scl_oe;
    w_busy_n       = r_busy;
    w_stretch_ld_n = r_stretch_ld;

    if (w_start) begin
      w_state_n      = ST_ADDR;
      w_bit_cnt_n    = '0;
      w_sda_oe_n     = 1'b0;
      w_scl_oe_n     = 1'b0;
      w_busy_n       = 1'b1;
      w_stretch_ld_n = 1'b0;
    end else if (w_stop) begin
      w_state_n      = ST_IDLE;
      w_sda_oe_n     = 1'b0;
      w_scl_oe_n     = 1'b0;
      w_busy_n       = 1'b0;
      w_stretch_ld_n = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_DATA: begin
          if (w_scl_rise && (r_bit_cnt < I2C_ACK_BIT)) begin
            w_shift_n   = {r_shift[I2C_DATA_W-2:0], w_sda_s};
            w_bit_cnt_n = r_bit_cnt + I2C_CNT_W'(1);
          end else if (w_scl_fall && (r_bit_cnt == I2C_ACK_BIT)) begin
            if (r_state == ST_ADDR) begin
              w_state_n  = w_addr_hit ? ST_ADDR_ACK : ST_IGNORE;
              w_sda_oe_n = w_addr_hit;
            end else if (w_slot_free) begin
              w_rx_data_n  = r_shift;
              w_rx_valid_n = 1'b1;
              w_sda_oe_n   = 1'b1;
              w_state_n    = ST_DATA_ACK;
            end else begin
              w_scl_oe_n = 1'b1;
              w_state_n  = ST_STRETCH;
            end
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_n  = 1'b0;
            w_bit_cnt_n = '0;
            w_state_n   = ST_DATA;
          end
        end
        ST_STRETCH: begin
          // Load first with SCL still held, release one cycle later
          if (r_stretch_ld) begin
            w_scl_oe_n     = 1'b0;
            w_stretch_ld_n = 1'b0;
            w_state_n      = ST_DATA_ACK;
          end else if (w_slot_free) begin
            w_rx_data_n    = r_shift;
            w_rx_valid_n   = 1'b1;
            w_sda_oe_n     = 1'b1;
            w_stretch_ld_n = 1'b1;
          end
        end
        ST_IGNORE: begin
          w_sda_oe_n = 1'b0;
          w_scl_oe_n = 1'b0;
        end
        ST_IDLE: begin
          w_sda_oe_n = 1'b0;
          w_scl_oe_n = 1'b0;
        end
        default: begin
          w_state_n  = ST_IDLE;
          w_sda_oe_n = 1'b0;
          w_scl_oe_n = 1'b0;
        end
      endcase
    end
  end

  assign scl_oe   = r_scl_oe;
  assign sda_oe   = r_sda_oe;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: a behavioural I2C master on an open-drain bus model,
// directed scenarios plus randomized transactions checked against an ACK/byte model.
module tb_i2c_target_rx;

  localparam int Q   = 6;
  localparam int H   = 12;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       rx_ready = 1'b0;
  logic       scl_oe, sda_oe, rx_valid, busy;
  logic [7:0] rx_data;
  logic       w_scl_line, w_sda_line;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] got_mem [0:255];
  int         got_cnt       = 0;
  int         valid_cycles  = 0;
  int         sda_oe_cycles = 0;
  int         scl_oe_cycles = 0;

  assign w_scl_line = m_scl & ~scl_oe;
  assign w_sda_line = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_rx #(
    .TARGET_ADDR (7'h50),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (w_scl_line),
    .sda_i    (w_sda_line),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy)
  );

  // Consumer-side capture of every accepted byte and line activity counters
  always @(posedge clk) begin
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      got_mem[got_cnt] <= rx_data;
      got_cnt          <= got_cnt + 1;
    end
    if (rx_valid === 1'b1) valid_cycles <= valid_cycles + 1;
    if (sda_oe === 1'b1) sda_oe_cycles <= sda_oe_cycles + 1;
    if (scl_oe === 1'b1) scl_oe_cycles <= scl_oe_cycles + 1;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic smp);
    int k;
    m_sda = b;
    wait_n(Q);
    m_scl = 1'b1;
    k = 0;
    while (w_scl_line !== 1'b1 && k < TMO) begin
      @(negedge clk);
      k++;
    end
    if (k >= TMO) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scl_release: scl line=%b, required 1 within %0d cycles", w_scl_line, TMO);
    end
    wait_n(H / 2);
    smp = w_sda_line;
    wait_n(H / 2);
    m_scl = 1'b0;
    wait_n(Q);
  endtask

  task automatic send_bits(input logic [7:0] d, input int nbits);
    logic s;
    for (int i = 7; i > 7 - nbits; i--) bus_bit(d[i], s);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    send_bits(d, 8);
    bus_bit(1'b1, ack);
  endtask

  task automatic send_start();
    if (m_scl == 1'b0) begin
      m_sda = 1'b1;
      wait_n(Q);
      m_scl = 1'b1;
      wait_n(H);
    end
    m_sda = 1'b0;
    wait_n(H);
    m_scl = 1'b0;
    wait_n(Q);
  endtask

  task automatic send_stop();
    m_sda = 1'b0;
    wait_n(Q);
    m_scl = 1'b1;
    wait_n(H);
    m_sda = 1'b1;
    wait_n(H);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    wait_n(3);
    n_cmp++;
    if ({scl_oe, sda_oe, rx_valid, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctl: scl_oe/sda_oe/rx_valid/busy=%b, required 0000", {scl_oe, sda_oe, rx_valid, busy});
    end
    n_cmp++;
    if (rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: rx_data=%h, required 00", rx_data);
    end
    rst_n = 1'b1;
    wait_n(4);
  endtask

  task automatic test_write_ack();
    logic ack;
    int   g0, v0, s0;
    rx_ready = 1'b1;
    g0 = got_cnt; v0 = valid_cycles; s0 = scl_oe_cycles;
    send_start();
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_start: busy=%b, required 1", busy); end
    send_byte({7'h50, 1'b0}, ack);
    n_cmp++;
    if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ack: sda=%b, required 0", ack); end
    send_byte(8'hA5, ack);
    n_cmp++;
    if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_data_ack: sda=%b, required 0", ack); end
    send_stop();
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_stop: busy=%b, required 0", busy); end
    n_cmp++;
    if (got_cnt - g0 != 1 || got_mem[g0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL wr_data: count=%0d byte=%h, required 1 byte A5", got_cnt - g0, got_mem[g0]);
    end
    n_cmp++;
    if (valid_cycles - v0 != 1) begin
      n_fail++;
      $display("FAIL wr_valid_len: rx_valid cycles=%0d, required 1", valid_cycles - v0);
    end
    n_cmp++;
    if (scl_oe_cycles != s0) begin
      n_fail++;
      $display("FAIL wr_no_stretch: scl_oe cycles=%0d, required 0", scl_oe_cycles - s0);
    end
  endtask

  task automatic test_addr_nack();
    logic ack;
    int   g0, d0;
    rx_ready = 1'b1;
    g0 = got_cnt; d0 = sda_oe_cycles;
    send_start();
    send_byte({7'h51, 1'b0}, ack);
    n_cmp++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL nack_addr: sda=%b, required 1", ack); end
    send_byte(8'h3C, ack);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL nack_busy: busy=%b, required 1", busy); end
    send_stop();
    n_cmp++;
    if (sda_oe_cycles != d0 || got_cnt != g0) begin
      n_fail++;
      $display("FAIL nack_quiet: sda_oe cycles=%0d bytes=%0d, required 0 and 0", sda_oe_cycles - d0, got_cnt - g0);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL nack_busy_stop: busy=%b, required 0", busy); end
  endtask

  task automatic test_stretch();
    logic ack;
    int   g0;
    rx_ready = 1'b0;
    g0 = got_cnt;
    send_start();
    send_byte({7'h50, 1'b0}, ack);
    send_byte(8'h11, ack);
    n_cmp++;
    if (ack !== 1'b0 || rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      n_fail++;
      $display("FAIL st_first: ack=%b valid=%b data=%h, required 0 1 11", ack, rx_valid, rx_data);
    end
    send_bits(8'h22, 8);
    wait_n(3);
    m_sda = 1'b1;
    m_scl = 1'b1;
    wait_n(20);
    n_cmp++;
    if (scl_oe !== 1'b1 || w_scl_line !== 1'b0 || rx_data !== 8'h11) begin
      n_fail++;
      $display("FAIL st_hold: scl_oe=%b scl=%b data=%h, required 1 0 11", scl_oe, w_scl_line, rx_data);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    n_cmp++;
    if (rx_data !== 8'h22 || rx_valid !== 1'b1 || scl_oe !== 1'b1 || sda_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL st_load: data=%h valid=%b scl_oe=%b sda_oe=%b, required 22 1 1 1", rx_data, rx_valid, scl_oe, sda_oe);
    end
    @(negedge clk);
    n_cmp++;
    if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL st_release: scl_oe=%b, required 0", scl_oe); end
    wait_n(H / 2);
    ack = w_sda_line;
    n_cmp++;
    if (ack !== 1'b0) begin n_fail++; $display("FAIL st_ack: sda=%b, required 0", ack); end
    wait_n(H / 2);
    m_scl = 1'b0;
    wait_n(Q);
    send_stop();
    n_cmp++;
    if (got_cnt - g0 != 1 || got_mem[g0] !== 8'h11) begin
      n_fail++;
      $display("FAIL st_first_out: count=%0d byte=%h, required 1 byte 11", got_cnt - g0, got_mem[g0]);
    end
    rx_ready = 1'b1;
    wait_n(2);
    n_cmp++;
    if (got_cnt - g0 != 2 || got_mem[g0 + 1] !== 8'h22 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL st_second_out: count=%0d byte=%h valid=%b, required 2 22 0", got_cnt - g0, got_mem[g0 + 1], rx_valid);
    end
  endtask

  task automatic test_repeated_start();
    logic       ack;
    logic [7:0] d;
    int         g0;
    rx_ready = 1'b1;
    g0 = got_cnt;
    d  = 8'($urandom);
    send_start();
    send_byte({7'h50, 1'b0}, ack);
    send_bits(8'($urandom), 4);
    send_start();
    send_byte({7'h50, 1'b0}, ack);
    n_cmp++;
    if (ack !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rs_addr_ack: sda=%b busy=%b, required 0 1", ack, busy);
    end
    send_byte(d, ack);
    send_stop();
    n_cmp++;
    if (got_cnt - g0 != 1 || got_mem[g0] !== d) begin
      n_fail++;
      $display("FAIL rs_data: count=%0d byte=%h, required 1 byte %h", got_cnt - g0, got_mem[g0], d);
    end
  endtask

  task automatic test_reset_in_stretch();
    logic       ack;
    logic [7:0] z;
    int         g0;
    rx_ready = 1'b0;
    send_start();
    send_byte({7'h50, 1'b0}, ack);
    send_byte(8'h5A, ack);
    send_bits(8'hC3, 8);
    wait_n(3);
    n_cmp++;
    if (scl_oe !== 1'b1) begin n_fail++; $display("FAIL rst_pre: scl_oe=%b, required 1", scl_oe); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({scl_oe, sda_oe, rx_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_release: scl_oe/sda_oe/rx_valid=%b, required 000", {scl_oe, sda_oe, rx_valid});
    end
    m_scl = 1'b1;
    m_sda = 1'b1;
    wait_n(3);
    rst_n = 1'b1;
    wait_n(5);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: busy=%b, required 0", busy); end
    rx_ready = 1'b1;
    g0 = got_cnt;
    z  = 8'($urandom);
    send_start();
    send_byte({7'h50, 1'b0}, ack);
    n_cmp++;
    if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_resume_ack: sda=%b, required 0", ack); end
    send_byte(z, ack);
    send_stop();
    n_cmp++;
    if (got_cnt - g0 != 1 || got_mem[g0] !== z) begin
      n_fail++;
      $display("FAIL rst_resume_data: count=%0d byte=%h, required 1 byte %h", got_cnt - g0, got_mem[g0], z);
    end
  endtask

  task automatic test_read_nack();
    logic ack;
    int   d0;
    d0 = sda_oe_cycles;
    send_start();
    send_byte({7'h50, 1'b1}, ack);
    n_cmp++;
    if (ack !== 1'b1 || busy !== 1'b1 || sda_oe_cycles != d0) begin
      n_fail++;
      $display("FAIL rd_nack: sda=%b busy=%b sda_oe cycles=%0d, required 1 1 0", ack, busy, sda_oe_cycles - d0);
    end
    send_stop();
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_stop: busy=%b, required 0", busy); end
  endtask

  // Model: a transaction is ACKed iff address matches and it is a write;
  // every byte of an ACKed write reaches the consumer in order, others none.
  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [6:0] a;
    logic       rw, ack, exp_ack;
    logic [7:0] d;
    int         nb, g0;
    rx_ready = 1'b1;
    g0 = got_cnt;
    for (int t = 0; t < 8; t++) begin
      a       = ($urandom_range(0, 2) != 0) ? 7'h50 : 7'($urandom);
      rw      = ($urandom_range(0, 3) == 0);
      nb      = $urandom_range(1, 3);
      exp_ack = (a == 7'h50) && !rw;
      send_start();
      send_byte({a, rw}, ack);
      n_cmp++;
      if (ack !== !exp_ack) begin
        n_fail++;
        $display("FAIL rnd_addr_ack[%0d]: addr=%h rw=%b sda=%b, required %b", t, a, rw, ack, !exp_ack);
      end
      for (int i = 0; i < nb; i++) begin
        d = 8'($urandom);
        if (exp_ack) exp_q.push_back(d);
        send_byte(d, ack);
        n_cmp++;
        if (ack !== !exp_ack) begin
          n_fail++;
          $display("FAIL rnd_data_ack[%0d.%0d]: sda=%b, required %b", t, i, ack, !exp_ack);
        end
      end
      send_stop();
    end
    wait_n(4);
    n_cmp++;
    if (got_cnt - g0 != exp_q.size()) begin
      n_fail++;
      $display("FAIL rnd_count: bytes=%0d, required %0d", got_cnt - g0, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (got_mem[g0 + i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rnd_byte[%0d]: got %h, required %h", i, got_mem[g0 + i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_addr_nack();
    test_stretch();
    test_repeated_start();
    test_reset_in_stretch();
    test_read_nack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
